// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with prioritised redirects, pending-redirect buffer and valid/ready fetch handshake.
// Optional misaligned-redirect trapping is enabled by defining PC_GEN_ALIGN_CHECK_EN.
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int NUM_REDIRECT = 3,
  parameter int IALIGN = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [NUM_REDIRECT-1:0]      redir_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0] redir_vect,
  input  logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [XLEN-1:0]              pc,
  output logic                         ena,
  output logic [NUM_REDIRECT-1:0]      redir_taken,
  output logic                         misalign,
  output logic [XLEN-1:0]              misalign_addr
);
  localparam logic [XLEN-1:0] AMASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);
  logic                    valid_q, pend_valid, any_redir, take, accept;
  logic [XLEN-1:0]         pend_vect, sel_vect, tgt;
  logic [NUM_REDIRECT-1:0] sel_oh;
  assign fetch_valid = valid_q & ~stall;
  assign accept      = fetch_valid & fetch_ready;
  assign ena         = accept;
  assign any_redir   = |redir_valid;
  // Walk from the highest index down so the lowest set channel wins.
  always_comb begin
    sel_oh   = '0;
    sel_vect = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--)
      if (redir_valid[i]) begin
        sel_oh   = NUM_REDIRECT'(1) << i;
        sel_vect = redir_vect[i*XLEN +: XLEN];
      end
  end
`ifdef PC_GEN_ALIGN_CHECK_EN
  logic bad;
  assign bad  = |(sel_vect & AMASK);
  assign take = any_redir & ~bad;
  assign tgt  = sel_vect;
  always_ff @(posedge clk)
    if (reset) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= any_redir & bad;
      if (any_redir & bad) misalign_addr <= sel_vect;
    end
`else
  assign take          = any_redir;
  assign tgt           = sel_vect & ~AMASK;
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      pc          <= RESET_VECTOR;
      valid_q     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_vect   <= '0;
      redir_taken <= '0;
    end else begin
      valid_q     <= 1'b1;
      redir_taken <= sel_oh;
      if (accept) begin
        pc         <= take ? tgt : pend_valid ? pend_vect : pc + XLEN'(4);
        pend_valid <= 1'b0;
      end else if (take) begin
        pend_valid <= 1'b1;
        pend_vect  <= tgt;
      end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a cycle-level reference model.
module tb_pc_gen;
  logic        clk = 0, reset, stall, fetch_ready;
  logic [2:0]  redir_valid;
  logic [95:0] redir_vect;
  logic        fetch_valid, ena, misalign;
  logic [31:0] pc, misalign_addr;
  logic [2:0]  redir_taken;
  int chk = 0, err = 0;
  logic [31:0] m_pc, m_pvec, m_maddr;
  logic        m_vq, m_pv, m_mis;
  logic [2:0]  m_taken;
  logic [31:0] issued[$];

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .NUM_REDIRECT(3), .IALIGN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid), .redir_vect(redir_vect),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc(pc), .ena(ena),
    .redir_taken(redir_taken), .misalign(misalign), .misalign_addr(misalign_addr));

  always #5 clk = ~clk;

  // Advance one clock: log issued addresses and step the reference model with the current inputs.
  task automatic tick();
    int idx;
    logic [31:0] t;
    logic acc, ok, bad;
    #1;
    if (ena) issued.push_back(pc);
    idx = -1;
    for (int i = 0; i < 3; i++) if (idx < 0 && redir_valid[i]) idx = i;
    t = (idx >= 0) ? redir_vect[idx*32 +: 32] : 32'h0;
    bad = (t % 4) != 0;
`ifdef PC_GEN_ALIGN_CHECK_EN
    ok = (idx >= 0) && !bad;
`else
    ok = idx >= 0;
    t = t - (t % 4);
`endif
    acc = m_vq && !stall && fetch_ready;
    if (reset) begin
      m_pc = 32'h100; m_vq = 0; m_pv = 0; m_pvec = 0; m_taken = 0; m_mis = 0; m_maddr = 0;
    end else begin
      if (acc) begin
        m_pc = ok ? t : m_pv ? m_pvec : m_pc + 4;
        m_pv = 0;
      end else if (ok) begin
        m_pv = 1; m_pvec = t;
      end
      m_taken = (idx >= 0) ? 3'(1 << idx) : 3'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
      m_mis = (idx >= 0) && bad;
      if (m_mis) m_maddr = redir_vect[idx*32 +: 32];
`endif
      m_vq = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_redir(input int ch, input logic [31:0] a);
    redir_valid[ch] = 1'b1;
    redir_vect[ch*32 +: 32] = a;
  endtask

  task automatic jump(input logic [31:0] a);
    fetch_ready = 1; stall = 0; set_redir(0, a);
    tick();
    redir_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; fetch_ready = 1; redir_valid = 0; redir_vect = '0;
    tick(); tick();
    chk++; if (pc !== 32'h100) begin err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
    chk++; if (fetch_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
    chk++; if (redir_taken !== 3'b0 || misalign !== 1'b0 || misalign_addr !== 32'h0) begin
      err++; $display("FAIL reset_regs got %b %b %h exp 000 0 0", redir_taken, misalign, misalign_addr); end
    reset = 0;
    #1;
    chk++; if (fetch_valid !== 1'b0) begin err++; $display("FAIL release_valid got %b exp 0", fetch_valid); end
    tick();
    chk++; if (fetch_valid !== 1'b1 || pc !== 32'h100) begin
      err++; $display("FAIL first_fetch got %b %h exp 1 00000100", fetch_valid, pc); end
    tick();
    chk++; if (pc !== 32'h104) begin err++; $display("FAIL seq1 got %h exp 00000104", pc); end
    tick();
    chk++; if (pc !== 32'h108) begin err++; $display("FAIL seq2 got %h exp 00000108", pc); end
  endtask

  task automatic test_priority();
    set_redir(1, 32'h2000); set_redir(2, 32'h3000);
    #1;
    chk++; if (ena !== 1'b1) begin err++; $display("FAIL prio_ena got %b exp 1", ena); end
    tick();
    redir_valid = 0;
    chk++; if (pc !== 32'h2000) begin err++; $display("FAIL prio_pc got %h exp 00002000", pc); end
    chk++; if (redir_taken !== 3'b010) begin err++; $display("FAIL prio_taken got %b exp 010", redir_taken); end
  endtask

  task automatic test_pending();
    bit seen = 0;
    jump(32'h40);
    issued.delete();
    fetch_ready = 0; set_redir(0, 32'h800);
    tick();
    redir_valid = 0; set_redir(2, 32'h900);
    chk++; if (pc !== 32'h40 || redir_taken !== 3'b001) begin
      err++; $display("FAIL pend_first got %h %b exp 00000040 001", pc, redir_taken); end
    tick();
    redir_valid = 0;
    chk++; if (redir_taken !== 3'b100) begin err++; $display("FAIL pend_taken got %b exp 100", redir_taken); end
    for (int k = 0; k < 3; k++) begin
      chk++; if (pc !== 32'h40 || ena !== 1'b0) begin
        err++; $display("FAIL pend_hold%0d got %h %b exp 00000040 0", k, pc, ena); end
      tick();
    end
    fetch_ready = 1;
    tick();
    chk++; if (pc !== 32'h900) begin err++; $display("FAIL pend_pc got %h exp 00000900", pc); end
    tick();
    foreach (issued[k]) if (issued[k] == 32'h800) seen = 1;
    chk++; if (seen) begin err++; $display("FAIL pend_lost got issued 00000800 exp never"); end
  endtask

  task automatic test_stall();
    jump(32'h10);
    stall = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk++; if (fetch_valid !== 1'b0 || ena !== 1'b0 || pc !== 32'h10) begin
        err++; $display("FAIL stall%0d got %b %b %h exp 0 0 00000010", k, fetch_valid, ena, pc); end
      tick();
    end
    stall = 0;
    #1;
    chk++; if (ena !== 1'b1) begin err++; $display("FAIL stall_resume got %b exp 1", ena); end
    tick();
    chk++; if (pc !== 32'h14) begin err++; $display("FAIL stall_next got %h exp 00000014", pc); end
  endtask

  task automatic test_wrap_and_reset();
    bit seen = 0;
    jump(32'hFFFF_FFFC);
    chk++; if (pc !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_load got %h exp fffffffc", pc); end
    tick();
    chk++; if (pc !== 32'h0) begin err++; $display("FAIL wrap got %h exp 00000000", pc); end
    issued.delete();
    fetch_ready = 0; set_redir(0, 32'h500);
    tick();
    redir_valid = 0; reset = 1;
    tick();
    reset = 0; fetch_ready = 1;
    tick();
    chk++; if (pc !== 32'h100 || fetch_valid !== 1'b1) begin
      err++; $display("FAIL rst_pend got %h %b exp 00000100 1", pc, fetch_valid); end
    tick();
    chk++; if (pc !== 32'h104) begin err++; $display("FAIL rst_pend_seq got %h exp 00000104", pc); end
    foreach (issued[k]) if (issued[k] == 32'h500) seen = 1;
    chk++; if (seen) begin err++; $display("FAIL rst_pend_lost got issued 00000500 exp never"); end
  endtask

  task automatic test_align();
    jump(32'h20);
    set_redir(0, 32'h1002);
    tick();
    redir_valid = 0;
`ifdef PC_GEN_ALIGN_CHECK_EN
    chk++; if (pc !== 32'h24 || misalign !== 1'b1 || misalign_addr !== 32'h1002) begin
      err++; $display("FAIL align_trap got %h %b %h exp 00000024 1 00001002", pc, misalign, misalign_addr); end
    tick();
    chk++; if (misalign !== 1'b0 || misalign_addr !== 32'h1002) begin
      err++; $display("FAIL align_pulse got %b %h exp 0 00001002", misalign, misalign_addr); end
`else
    chk++; if (pc !== 32'h1000 || misalign !== 1'b0) begin
      err++; $display("FAIL align_force got %h %b exp 00001000 0", pc, misalign); end
    tick();
    chk++; if (misalign !== 1'b0 || misalign_addr !== 32'h0) begin
      err++; $display("FAIL align_tied got %b %h exp 0 00000000", misalign, misalign_addr); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      fetch_ready = ($urandom_range(0, 2) != 0);
      redir_valid = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b0;
      for (int c = 0; c < 3; c++)
        redir_vect[c*32 +: 32] = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      #1;
      chk++; if (fetch_valid !== (m_vq && !stall) || ena !== (m_vq && !stall && fetch_ready)) begin
        err++; $display("FAIL rnd%0d_hs got %b %b exp %b %b", n, fetch_valid, ena, m_vq && !stall, m_vq && !stall && fetch_ready); end
      chk++; if (pc !== m_pc || redir_taken !== m_taken) begin
        err++; $display("FAIL rnd%0d_pc got %h %b exp %h %b", n, pc, redir_taken, m_pc, m_taken); end
      chk++; if (misalign !== m_mis || misalign_addr !== m_maddr) begin
        err++; $display("FAIL rnd%0d_mis got %b %h exp %b %h", n, misalign, misalign_addr, m_mis, m_maddr); end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_pending();
    test_stall();
    test_wrap_and_reset();
    test_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator at the head of the fetch stage.
- Successor to the single-vector PC: accepts N prioritised redirect channels, XLEN-wide addresses and a configurable reset vector.
- Issues fetch addresses to instruction memory over a valid/ready handshake.
- Buffers a redirect that arrives while the current fetch is not yet accepted, so no redirect is lost.

## Interface
Parameters:
- XLEN, 32, address width.
- RESET_VECTOR, 32'h00000000, PC value loaded by reset.
- NUM_REDIRECT, 3, number of redirect channels (≥1); channel 0 has highest priority.
- IALIGN, 32, instruction alignment in bits (32 or 16); used only by the alignment check.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  freeze PC; forces fetch_valid low.
- redir_valid  in  NUM_REDIRECT  per-channel redirect request.
- redir_vect  in  NUM_REDIRECT*XLEN  targets; channel i at [i*XLEN +: XLEN].
- fetch_ready  in  1  instruction memory accepts the current address.
- fetch_valid  out  1  current pc is a fetch request.
- pc  out  XLEN  current fetch address.
- ena  out  1  instruction memory enable; equals accept.
- redir_taken  out  NUM_REDIRECT  registered one-hot of the channel selected last cycle.
- misalign  out  1  one-cycle misaligned-redirect pulse.
- misalign_addr  out  XLEN  offending target.

## Operation
- State: pc, valid_q, pend_valid, pend_vect, redir_taken, misalign, misalign_addr.
- fetch_valid = valid_q & ~stall (combinational). accept = fetch_valid & fetch_ready.
- The instruction memory treats a deasserted fetch_valid as no request; valid need not persist across stall.
- Redirect select: lowest index i with redir_valid[i] set; sel_vect = that channel's target. Any-redirect = |redir_valid.
- Next-pc priority, evaluated only when accept = 1:
  1. Any-redirect this cycle: pc <= sel_vect; pend_valid <= 0.
  2. Otherwise pend_valid = 1: pc <= pend_vect; pend_valid <= 0.
  3. Otherwise: pc <= pc + 4, modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at XLEN=32).
- When accept = 0 and any-redirect = 1: pend_valid <= 1 and pend_vect <= sel_vect.
  - A newer redirect overwrites an older pending one.
  - pc does not change.
- When accept = 0 and no redirect: pc and pend are held.
- redir_taken <= one-hot of the selected channel whenever any-redirect = 1, including when the target is captured into pend; otherwise 0.
- Alignment check (see Configuration): low bits are [1:0] for IALIGN=32 and [0] for IALIGN=16.

## Timing
- Reset values: pc=RESET_VECTOR, valid_q=0, pend_valid=0, pend_vect=0, redir_taken=0, misalign=0, misalign_addr=0.
- With stall=0, fetch_valid is first high in the first cycle after reset deasserts, with pc=RESET_VECTOR.
- Reset asserted mid-operation overrides everything in that cycle: pending redirect is discarded and pc returns to RESET_VECTOR.
- Latency: a redirect in cycle t with accept in t gives pc=target in t+1. Without accept, pc takes the target in the cycle after the first accept.
- A redirect and accept in the same cycle as a pending entry: the new redirect wins and the pending entry is dropped.
- Stall has priority over fetch_ready; pc and pend are held. Redirects are still captured into pend during stall.
- misalign and redir_taken are registered: both are valid in cycle t+1 for a redirect in cycle t.

## Configuration
- PC_GEN_ALIGN_CHECK_EN defined:
  - A selected target with nonzero alignment bits is discarded: not loaded into pc and not written to pend.
  - Any existing pending entry is kept.
  - misalign pulses high for one cycle in t+1 and misalign_addr <= target (held until the next misalign).
  - Sequential fetch continues per the rules above.
- Undefined:
  - Alignment bits of every target are forced to zero before use.
  - misalign and misalign_addr are tied to 0.

## Test plan
- Reset release, stall=0, fetch_ready=1, RESET_VECTOR=0x100 -> pc sequence 0x100, 0x104, 0x108; fetch_valid first high one cycle after reset.
- redir_valid=3'b110 with targets ch1=0x2000 and ch2=0x3000, accept high -> next pc 0x2000; redir_taken=3'b010 next cycle.
- fetch_ready=0 at pc=0x40; redirect to 0x800, then a redirect to 0x900 one cycle later; ready rises 3 cycles after that -> pc stays 0x40, then becomes 0x900; 0x800 is never issued.
- stall=1 for 4 cycles at pc=0x10 with ready=1 -> fetch_valid=0, ena=0, pc held at 0x10; resumes at 0x14.
- pc=0xFFFFFFFC with accept -> pc wraps to 0x00000000. Reset asserted while a pending entry holds 0x500 -> pc=RESET_VECTOR and 0x500 is never issued.
- PC_GEN_ALIGN_CHECK_EN, IALIGN=32, redirect to 0x1002 at pc=0x20 -> pc=0x24, misalign=1 for one cycle, misalign_addr=0x1002. Without the macro -> pc=0x1000 and misalign stays 0.
